// File: rtl/seg_pkg.sv
// Shared constants for the 7-segment display blocks (scan mux, decoder, dividers).
package seg_pkg;
  localparam int NUM_DIGITS          = 4;
  localparam int DIGIT_W             = 4;
  localparam int DEFAULT_REFRESH_DIV = 100000;
  localparam logic [NUM_DIGITS-1:0] AN_ALL_OFF = 4'b1111;

  typedef logic [1:0] digit_idx_t;
endpackage

// File: rtl/seg_scan_mux_if.sv
// Bundle between a digit source/observer (master) and the scan mux (slave).
interface seg_scan_mux_if;
  import seg_pkg::*;

  logic [NUM_DIGITS*DIGIT_W-1:0] digits_in;
  logic                          load;
  logic                          blank_lz;
  logic [DIGIT_W-1:0]            bcd_out;
  logic [NUM_DIGITS-1:0]         an;
  digit_idx_t                    digit_sel;
  logic                          frame_start;

  modport master (
    output digits_in, load, blank_lz,
    input  bcd_out, an, digit_sel, frame_start
  );

  modport slave (
    input  digits_in, load, blank_lz,
    output bcd_out, an, digit_sel, frame_start
  );
endinterface

// File: rtl/refresh_tick.sv
// Free-running divider: tick is high for one cycle out of every REFRESH_DIV.
module refresh_tick #(
  parameter int REFRESH_DIV = seg_pkg::DEFAULT_REFRESH_DIV,
  parameter int CNT_W       = $clog2(REFRESH_DIV)
) (
  input  logic clk,
  input  logic rst_n,
  output logic tick
);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(REFRESH_DIV - 1);

  logic [CNT_W-1:0] div;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      div <= '0;
    end else if (div == LAST) begin
      div <= '0;
    end else begin
      div <= div + CNT_W'(1);
    end
  end

  assign tick = (div == LAST);
endmodule

// File: rtl/seg_scan_mux.sv
// Time-multiplexed scan of a double-buffered 4-digit BCD value onto one
// common-anode digit at a time; new values commit only at frame wrap.
module seg_scan_mux
  import seg_pkg::*;
#(
  parameter int REFRESH_DIV = DEFAULT_REFRESH_DIV,
  parameter int CNT_W       = $clog2(REFRESH_DIV)
) (
  input  logic           clk,
  input  logic           rst_n,
  seg_scan_mux_if.slave  bus
);
  localparam int VAL_W = NUM_DIGITS * DIGIT_W;

  logic                  tick;
  logic [VAL_W-1:0]      disp, pend, disp_next;
  logic                  pend_valid;
  digit_idx_t            sel, sel_next;
  logic [DIGIT_W-1:0]    bcd;
  logic [NUM_DIGITS-1:0] an, an_next;
  logic                  frame_start;
  logic                  wrap;

  // Digit i (i>0) goes dark when it and every digit above it are zero.
  function automatic logic is_blanked(input logic [VAL_W-1:0] d,
                                      input digit_idx_t i,
                                      input logic en);
    logic all_zero;
    all_zero = 1'b1;
    for (int j = 1; j < NUM_DIGITS; j++) begin
      if (j >= int'(i)) all_zero = all_zero & (d[j*DIGIT_W +: DIGIT_W] == '0);
    end
    return en && (i != '0) && all_zero;
  endfunction

  refresh_tick #(
    .REFRESH_DIV (REFRESH_DIV),
    .CNT_W       (CNT_W)
  ) u_tick (
    .clk   (clk),
    .rst_n (rst_n),
    .tick  (tick)
  );

  always_comb begin
    wrap      = (sel == digit_idx_t'(NUM_DIGITS - 1));
    sel_next  = sel + digit_idx_t'(1);
    disp_next = disp;
    // A load coinciding with the wrap skips the pending buffer entirely.
    if (wrap) begin
      if (bus.load)       disp_next = bus.digits_in;
      else if (pend_valid) disp_next = pend;
    end
    an_next = is_blanked(disp_next, sel_next, bus.blank_lz)
              ? AN_ALL_OFF : ~(NUM_DIGITS'(1) << sel_next);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      disp        <= '0;
      pend        <= '0;
      pend_valid  <= 1'b0;
      sel         <= '0;
      bcd         <= '0;
      an          <= 4'b1110;
      frame_start <= 1'b0;
    end else begin
      frame_start <= tick && wrap;
      if (tick && wrap) begin
        disp       <= disp_next;
        pend_valid <= 1'b0;
      end else if (bus.load) begin
        pend       <= bus.digits_in;
        pend_valid <= 1'b1;
      end
      if (tick) begin
        sel <= sel_next;
        bcd <= disp_next[sel_next*DIGIT_W +: DIGIT_W];
        an  <= an_next;
      end
    end
  end

  assign bus.bcd_out     = bcd;
  assign bus.an          = an;
  assign bus.digit_sel   = sel;
  assign bus.frame_start = frame_start;
endmodule

// File: tb/tb_seg_scan_mux.sv
// Randomized and directed bench for seg_scan_mux with REFRESH_DIV=4.
module tb_seg_scan_mux;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  seg_scan_mux_if bus();

  seg_scan_mux #(.REFRESH_DIV(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int total = 0;
  int bad   = 0;

  // Reference state: k = clock edges since reset release; slots are 4 edges,
  // frames 16 edges, so digit index and frame boundaries follow from k alone.
  int          k;
  logic [15:0] m_disp, m_pend;
  logic        m_pv, m_blz;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (k=%0d)", tag, got, exp, k);
    end
  endtask

  function automatic logic [3:0] nib(input logic [15:0] v, input int i);
    return v[i*4 +: 4];
  endfunction

  function automatic logic lead_zero(input logic [15:0] v, input int i);
    for (int j = i; j < 4; j++) if (nib(v, j) != 4'h0) return 1'b0;
    return 1'b1;
  endfunction

  task automatic model_edge();
    if (!rst_n) begin
      k = 0; m_disp = '0; m_pend = '0; m_pv = 1'b0; m_blz = 1'b0;
    end else begin
      k++;
      if (k % 16 == 0) begin
        if (bus.load) begin
          m_disp = bus.digits_in; m_pv = 1'b0;
        end else if (m_pv) begin
          m_disp = m_pend; m_pv = 1'b0;
        end
      end else if (bus.load) begin
        m_pend = bus.digits_in; m_pv = 1'b1;
      end
      if (k % 4 == 0) m_blz = bus.blank_lz;
    end
  endtask

  task automatic check_outputs();
    int       sel;
    logic [3:0] exp_an;
    logic [3:0] exp_bcd;
    sel     = (k / 4) % 4;
    exp_bcd = nib(m_disp, sel);
    if (m_blz && sel != 0 && lead_zero(m_disp, sel)) exp_an = 4'b1111;
    else                                             exp_an = ~(4'b0001 << sel);
    chk("digit_sel", 32'(bus.digit_sel), 32'(sel));
    chk("bcd_out", 32'(bus.bcd_out), 32'(exp_bcd));
    chk("an", 32'(bus.an), 32'(exp_an));
    chk("frame_start", 32'(bus.frame_start), 32'(k > 0 && k % 16 == 0));
    chk("an_onehot", 32'($countones(~bus.an) <= 1), 32'd1);
  endtask

  task automatic cyc();
    @(posedge clk);
    model_edge();
    @(negedge clk);
    check_outputs();
  endtask

  task automatic load_val(input logic [15:0] d);
    bus.digits_in = d;
    bus.load      = 1'b1;
    cyc();
    bus.load      = 1'b0;
  endtask

  // Advance at least one cycle, then until the frame phase k%16 equals p.
  task automatic to_phase(input int p);
    int guard;
    guard = 0;
    cyc();
    while (k % 16 != p && guard < 40) begin
      cyc();
      guard++;
    end
    chk("phase_reached", 32'(k % 16), 32'(p));
  endtask

  // Next frame: slot s must show nibble s of exp_bcd and nibble s of exp_an.
  task automatic frame_expect(input string tag, input logic [15:0] exp_bcd,
                              input logic [15:0] exp_an);
    to_phase(0);
    for (int s = 0; s < 4; s++) begin
      chk({tag, "_bcd"}, 32'(bus.bcd_out), 32'(nib(exp_bcd, s)));
      chk({tag, "_an"}, 32'(bus.an), 32'(nib(exp_an, s)));
      if (s < 3) repeat (4) cyc();
    end
  endtask

  initial begin
    logic [15:0] d;
    bus.digits_in = '0;
    bus.load      = 1'b0;
    bus.blank_lz  = 1'b0;
    k = 0; m_disp = '0; m_pend = '0; m_pv = 1'b0; m_blz = 1'b0;

    // Reset held 3 cycles, with a load that must be dropped
    bus.digits_in = 16'h4321;
    bus.load      = 1'b1;
    repeat (3) cyc();
    bus.load = 1'b0;
    chk("rst_an", 32'(bus.an), 32'h0000000E);
    chk("rst_bcd", 32'(bus.bcd_out), 32'd0);
    chk("rst_sel", 32'(bus.digit_sel), 32'd0);
    chk("rst_fs", 32'(bus.frame_start), 32'd0);
    rst_n = 1'b1;
    repeat (3) cyc();
    chk("pre_advance_sel", 32'(bus.digit_sel), 32'd0);
    cyc();
    chk("first_advance_sel", 32'(bus.digit_sel), 32'd1);

    // Plain scan
    load_val(16'h1234);
    frame_expect("scan1234", 16'h1234, 16'h7BDE);

    // Tear-free commit while digit 1 is showing
    to_phase(4);
    load_val(16'h5678);
    chk("tear_d1", 32'(bus.bcd_out), 32'd3);
    to_phase(8);
    chk("tear_d2", 32'(bus.bcd_out), 32'd2);
    to_phase(12);
    chk("tear_d3", 32'(bus.bcd_out), 32'd1);
    to_phase(0);
    chk("tear_commit", 32'(bus.bcd_out), 32'd8);

    // Load on the exact wrap cycle bypasses pend
    to_phase(15);
    load_val(16'h9999);
    chk("bypass_bcd", 32'(bus.bcd_out), 32'd9);
    chk("bypass_an", 32'(bus.an), 32'h0000000E);

    // Double load: last one wins
    to_phase(2);
    load_val(16'h1111);
    to_phase(6);
    load_val(16'h2222);
    frame_expect("double", 16'h2222, 16'h7BDE);

    // Leading-zero blanking
    bus.blank_lz = 1'b1;
    load_val(16'h0070);
    frame_expect("blank0070", 16'h0070, 16'hFFDE);
    load_val(16'h0000);
    frame_expect("blank0000", 16'h0000, 16'hFFFE);

    // Reset mid-frame
    load_val(16'h8765);
    to_phase(6);
    rst_n = 1'b0;
    cyc();
    chk("midrst_an", 32'(bus.an), 32'h0000000E);
    chk("midrst_bcd", 32'(bus.bcd_out), 32'd0);
    chk("midrst_sel", 32'(bus.digit_sel), 32'd0);
    chk("midrst_fs", 32'(bus.frame_start), 32'd0);
    rst_n = 1'b1;

    // Random traffic against the model
    for (int n = 0; n < 1500; n++) begin
      d = 16'($urandom);
      bus.digits_in = d >> (4 * $urandom_range(0, 3));
      bus.load      = ($urandom_range(0, 4) == 0);
      if ($urandom_range(0, 39) == 0) bus.blank_lz = ~bus.blank_lz;
      rst_n = ($urandom_range(0, 299) != 0);
      cyc();
    end
    bus.load = 1'b0;
    rst_n    = 1'b1;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
